sram_conf_responder: RTL and testbench
======================================

Name: sram_conf_responder

Overview:
Responder end of the core's data SRAM interface (en / byte-wen / addr / wdata / rdata), instantiated in the SoC shell opposite the CPU top.
Decodes each request to an on-chip word RAM or to a small memory-mapped device-register window: LED, number display, switch input and a free-running timer.
Read data is registered and appears one clk edge after the request. The core runs its datapath on inverted clk, so it sees that data within the same core cycle.

Parameters:
RAM_AW, 12, RAM word-address width (depth 2**RAM_AW words of 32 bits)
CONF_HI, 16'h1faf, value of addr[31:16] that selects the device-register window
SW_W, 8, switch input width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
sram_en  input  1  request valid this cycle
sram_wen  input  4  byte write enables; nonzero means write, zero means read
sram_addr  input  32  physical byte address; bits [1:0] ignored
sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i]
sram_rdata  output  32  registered read data
led  output  16  LED register
num_data  output  32  seven-segment display value register
switch  input  SW_W  asynchronous board switches

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Decode: conf = (sram_addr[31:16] == CONF_HI); otherwise RAM at word index sram_addr[RAM_AW+1:2]. Upper RAM address bits alias.
- Conf offsets (sram_addr[15:0]):
  - 16'hF000: LED, RW, bits [15:0]
  - 16'hF010: NUM, RW, 32 bits
  - 16'hF030: SWITCH, RO, zero-extended
  - 16'hE000: TIMER, RW
  - Any other offset reads 0; writes to it are ignored.
- Read (sram_en=1, sram_wen=0):
  - At that posedge, sram_rdata <= selected RAM word or conf value.
  - Latency is exactly 1 edge; no stall and no handshake.
- Write (sram_en=1, sram_wen!=0):
  - RAM: each set wen bit writes its byte lane; other lanes are kept.
  - Conf: the register is written only when sram_wen==4'hF. A partial write is ignored.
  - sram_rdata holds its previous value.
- sram_en=0: no state change except the timer; sram_rdata holds.
- TIMER:
  - Increments by 1 on every posedge and wraps 32'hFFFFFFFF -> 0.
  - A full-word write loads sram_wdata at that edge, and the load takes precedence over the increment.
  - A read returns the pre-edge value.
- SWITCH: two-flop synchronizer on the switch input; reads return the second-stage value.
- Reset (async, any time, including mid-request): sram_rdata=0, led=0, num_data=0, timer=0, synchronizer flops=0.
  - RAM contents are not reset.
  - The first edge after rst deasserts behaves as normal; a request in flight when rst asserts is dropped.
- The single port never sees a simultaneous read and write; a write never forwards to sram_rdata.

Decomposition:
- Shared package sram_conf_pkg holds:
  - offset constants LED_OFF, NUM_OFF, SW_OFF, TIMER_OFF
  - default CONF_HI
  - a 32-bit constant ZERO_WORD
- One natural sub-module: sram_byte_ram (single-port, byte-write, registered-read RAM of 2**RAM_AW x 32).
- The top holds the decode, the conf registers, the timer, the synchronizer and the rdata mux register.

Test Plan:
- RAM byte write: write 32'h11223344 (wen=F) to 0x00000010, then wen=4'b0010 data 32'hAABBCCDD to the same address, then read -> sram_rdata=32'h1122CC44 one edge after the read.
- Read latency and hold: read 0x00000010, then 3 cycles with en=0 -> rdata=32'h1122CC44 stable through all 3 cycles.
- LED and NUM:
  - Write 32'h0000A5A5 to 0x1FAFF000 -> led=16'hA5A5 the next edge.
  - Write 32'hDEADBEEF to 0x1FAFF010 -> num_data=32'hDEADBEEF.
  - Write to 0x1FAFF000 with wen=4'b0011 -> led unchanged.
- Timer:
  - Write 32'hFFFFFFFE to 0x1FAFE000, then read it 1 edge later -> 32'hFFFFFFFE.
  - The following read -> 32'hFFFFFFFF.
  - The next read -> 0 (wrap).
- Switch and unmapped:
  - Set switch=8'h5C, wait 3 edges, read 0x1FAFF030 -> 32'h0000005C.
  - Read 0x1FAF1234 -> 0.
- Async reset mid-operation: after LED=16'hA5A5 and timer running, assert rst between edges -> led, num_data, sram_rdata and timer read back as 0 immediately. The RAM word at 0x10 still reads 32'h1122CC44 after release.

Source files
------------

// File: rtl/sram_conf_pkg.sv
// Shared constants for the SRAM responder: device-register window offsets,
// the default window select value and a zero word for read-mux defaults.
package sram_conf_pkg;

    // Offsets within the device-register window (sram_addr[15:0])
    localparam logic [15:0] LED_OFF   = 16'hF000;
    localparam logic [15:0] NUM_OFF   = 16'hF010;
    localparam logic [15:0] SW_OFF    = 16'hF030;
    localparam logic [15:0] TIMER_OFF = 16'hE000;

    // Default value of sram_addr[31:16] that selects the register window
    localparam logic [15:0] CONF_HI_DEFAULT = 16'h1faf;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/sram_byte_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-high reset (clears the read register only)
//   en_i     - access valid
//   wen_i    - byte write enables; zero means read
//   addr_i   - word address
//   wdata_i  - write data, byte lane i = bits [8i+7:8i]
//   rdata_o  - read data, updated one edge after a read, held otherwise
module sram_byte_ram #(
    parameter int unsigned AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [3:0]    wen_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    // Contents are never reset; a write presented while reset is held is dropped.
    always_ff @(posedge clk_i) begin
        if (en_i && !rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wen_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && (wen_i == 4'h0)) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_conf_responder.sv
// Responder side of the core's data SRAM interface. Decodes each request to the
// on-chip word RAM or to the device-register window (LED, number display,
// switch input, free-running timer). Read data appears one clk edge after the
// request and holds until the next read.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   sram_en/wen/addr/wdata - request; wen nonzero is a write, zero is a read
//   sram_rdata          - registered read data
//   led, num_data       - device output registers
//   switch              - asynchronous board switches (synchronized internally)
module sram_conf_responder
    import sram_conf_pkg::*;
#(
    parameter int unsigned RAM_AW  = 12,
    parameter logic [15:0] CONF_HI = CONF_HI_DEFAULT,
    parameter int unsigned SW_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sram_en,
    input  logic [3:0]      sram_wen,
    input  logic [31:0]     sram_addr,
    input  logic [31:0]     sram_wdata,
    output logic [31:0]     sram_rdata,
    output logic [15:0]     led,
    output logic [31:0]     num_data,
    input  logic [SW_W-1:0] switch
);

    logic        is_conf;
    logic [15:0] conf_off;
    logic        rd_req;
    logic        conf_wr;
    logic        ram_en;
    logic [31:0] ram_rdata;
    logic [31:0] conf_val;

    logic [15:0]     led_q;
    logic [31:0]     num_q;
    logic [31:0]     timer_q, timer_d;
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;
    logic [31:0]     conf_rdata_q;
    logic            rsel_ram_q;

    assign is_conf  = (sram_addr[31:16] == CONF_HI);
    assign conf_off = sram_addr[15:0];
    assign rd_req   = sram_en && (sram_wen == 4'h0);
    // Device registers accept full-word writes only
    assign conf_wr  = sram_en && is_conf && (sram_wen == 4'hF);
    assign ram_en   = sram_en && !is_conf;

    sram_byte_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (ram_en),
        .wen_i   (sram_wen),
        .addr_i  (sram_addr[RAM_AW+1:2]),
        .wdata_i (sram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        conf_val = ZERO_WORD;
        case (conf_off)
            LED_OFF:   conf_val = {16'h0000, led_q};
            NUM_OFF:   conf_val = num_q;
            SW_OFF:    conf_val[SW_W-1:0] = sw_sync_q;
            TIMER_OFF: conf_val = timer_q;
            default:   conf_val = ZERO_WORD;
        endcase
    end

    // A load takes precedence over the free-running increment
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (conf_wr && (conf_off == TIMER_OFF)) begin
            timer_d = sram_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q        <= '0;
            num_q        <= '0;
            timer_q      <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            conf_rdata_q <= '0;
            rsel_ram_q   <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            if (conf_wr && (conf_off == LED_OFF)) begin
                led_q <= sram_wdata[15:0];
            end
            if (conf_wr && (conf_off == NUM_OFF)) begin
                num_q <= sram_wdata;
            end
            // Remember the source of the last read; both sources hold otherwise
            if (rd_req) begin
                rsel_ram_q <= !is_conf;
                if (is_conf) begin
                    conf_rdata_q <= conf_val;
                end
            end
        end
    end

    assign sram_rdata = rsel_ram_q ? ram_rdata : conf_rdata_q;
    assign led        = led_q;
    assign num_data   = num_q;

endmodule

// File: tb/tb_sram_conf_responder.sv
// Directed self-checking bench for sram_conf_responder.
module tb_sram_conf_responder;

    logic        clk;
    logic        rst;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] led;
    logic [31:0] num_data;
    logic [7:0]  switch;

    int checks = 0;
    int errors = 0;

    sram_conf_responder #(
        .RAM_AW  (12),
        .CONF_HI (16'h1faf),
        .SW_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .led        (led),
        .num_data   (num_data),
        .switch     (switch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: driven at negedge, sampled 1 time unit after the posedge
    task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        sram_en    = 1'b1;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wdata;
        @(posedge clk);
        #1;
        sram_en  = 1'b0;
        sram_wen = 4'h0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        sram_en    = 1'b0;
        sram_wen   = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        switch     = 8'h00;
        idle();
        idle();
        check("reset_rdata", sram_rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_num", num_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // RAM byte-lane write
        req(4'hF, 32'h0000_0010, 32'h1122_3344);
        req(4'b0010, 32'h0000_0010, 32'hAABB_CCDD);
        req(4'h0, 32'h0000_0010, 32'h0);
        check("ram_byte_write", sram_rdata, 32'h1122_CC44);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("ram_read_hold", sram_rdata, 32'h1122_CC44);
        end
        // Upper RAM address bits alias onto the same word
        req(4'h0, 32'h0000_4010, 32'h0);
        check("ram_alias", sram_rdata, 32'h1122_CC44);

        // LED / NUM registers
        req(4'hF, 32'h1FAF_F000, 32'h0000_A5A5);
        check("led_write", {16'h0, led}, 32'h0000_A5A5);
        req(4'hF, 32'h1FAF_F010, 32'hDEAD_BEEF);
        check("num_write", num_data, 32'hDEAD_BEEF);
        req(4'b0011, 32'h1FAF_F000, 32'h0000_1234);
        check("led_partial_ignored", {16'h0, led}, 32'h0000_A5A5);
        // A write does not disturb the held read data
        check("rdata_hold_on_write", sram_rdata, 32'h1122_CC44);
        req(4'h0, 32'h1FAF_F000, 32'h0);
        check("led_read", sram_rdata, 32'h0000_A5A5);
        req(4'h0, 32'h1FAF_F010, 32'h0);
        check("num_read", sram_rdata, 32'hDEAD_BEEF);

        // Timer load, increment and wrap
        req(4'hF, 32'h1FAF_E000, 32'hFFFF_FFFE);
        req(4'h0, 32'h1FAF_E000, 32'h0);
        check("timer_load", sram_rdata, 32'hFFFF_FFFE);
        req(4'h0, 32'h1FAF_E000, 32'h0);
        check("timer_inc", sram_rdata, 32'hFFFF_FFFF);
        req(4'h0, 32'h1FAF_E000, 32'h0);
        check("timer_wrap", sram_rdata, 32'h0);

        // Switch synchronizer and unmapped offset
        @(negedge clk);
        switch = 8'h5C;
        idle();
        idle();
        idle();
        req(4'h0, 32'h1FAF_F030, 32'h0);
        check("switch_read", sram_rdata, 32'h0000_005C);
        req(4'h0, 32'h1FAF_1234, 32'h0);
        check("unmapped_read", sram_rdata, 32'h0);
        req(4'hF, 32'h1FAF_1234, 32'hFFFF_FFFF);
        req(4'h0, 32'h1FAF_F000, 32'h0);
        check("unmapped_write_ignored", sram_rdata, 32'h0000_A5A5);

        // Async reset between edges, with a pending request
        req(4'h0, 32'h1FAF_E000, 32'h0);
        check("timer_running", (sram_rdata != 32'h0) ? 32'h1 : 32'h0, 32'h1);
        @(negedge clk);
        sram_en    = 1'b1;
        sram_wen   = 4'hF;
        sram_addr  = 32'h0000_0010;
        sram_wdata = 32'h0BAD_0BAD;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_led", {16'h0, led}, 32'h0);
        check("async_rst_num", num_data, 32'h0);
        check("async_rst_rdata", sram_rdata, 32'h0);
        @(posedge clk);
        #1;
        sram_en  = 1'b0;
        sram_wen = 4'h0;
        @(negedge clk);
        rst       = 1'b0;
        sram_en   = 1'b1;
        sram_wen  = 4'h0;
        sram_addr = 32'h1FAF_E000;
        @(posedge clk);
        #1;
        sram_en = 1'b0;
        check("async_rst_timer", sram_rdata, 32'h0);
        req(4'h0, 32'h0000_0010, 32'h0);
        check("ram_kept_over_reset", sram_rdata, 32'h1122_CC44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
